// File: rtl/poly_shift_reg.sv
// Parametrised polynomial / serial shift register with an XNOR LFSR that can run at full
// or short length, serial-in shifting, rotation, parallel load, preset and a period-wrap strobe.
module poly_shift_reg #(
  parameter int                    WIDTH      = 17,
  parameter int                    SHORT_LEN  = 9,
  parameter logic [WIDTH-1:0]      FULL_TAPS  = 17'h12000,
  parameter logic [WIDTH-1:0]      SHORT_TAPS = 17'h00110,
  parameter logic [WIDTH-1:0]      PRESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enn,
  input  logic [1:0]       mode,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             preset,
  input  logic             din,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ALL_MASK   = '1;
  localparam logic [WIDTH-1:0] SHORT_MASK = ALL_MASK >> (WIDTH - SHORT_LEN);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_seed;
  logic             r_wrap;

  logic             w_new_bit;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_next;
  logic             w_at_seed;

  always_comb begin
    w_new_bit = 1'b0;
    w_mask    = ALL_MASK;
    case (mode)
      2'b00: w_new_bit = ~^(r_q & FULL_TAPS);
      2'b01: begin
        w_new_bit = ~^(r_q & SHORT_TAPS);
        w_mask    = SHORT_MASK;
      end
      2'b10: w_new_bit = din;
      2'b11: w_new_bit = r_q[WIDTH-1];
      default: w_new_bit = 1'b0;
    endcase
    // Only the active window moves; bits above it keep their value.
    w_shifted = {r_q[WIDTH-2:0], w_new_bit};
    w_next    = (w_shifted & w_mask) | (r_q & ~w_mask);
    w_at_seed = ((w_next & w_mask) == (r_seed & w_mask));
  end

  always_ff @(negedge clk) begin
    if (reset || preset) begin
      r_q    <= PRESET_VAL;
      r_seed <= PRESET_VAL;
      r_wrap <= 1'b0;
    end else if (ld) begin
      r_q    <= d;
      r_seed <= d;
      r_wrap <= 1'b0;
    end else if (enn) begin
      r_q    <= w_next;
      r_wrap <= w_at_seed;
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign q    = r_q;
  assign wrap = r_wrap;
  assign sout = (mode == 2'b01) ? r_q[SHORT_LEN-1] : r_q[WIDTH-1];

endmodule
